// File: rtl/mips_dmem_sequencer.sv
// Multi-cycle data-memory sequencer for the MIPS core: issues one request per
// load/store, steers byte lanes, extracts load data and stalls until done.
module mips_dmem_sequencer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             op_valid,
  input  logic             mem_read,
  input  logic             word_we,
  input  logic             byte_we,
  input  logic             byte_load,
  input  logic [31:0]      addr,
  input  logic [31:0]      store_data,
  output logic             mem_req,
  output logic             mem_we,
  output logic [3:0]       mem_be,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic             mem_ack,
  input  logic [31:0]      mem_rdata,
  output logic             stall,
  output logic [31:0]      load_data,
  output logic             rf_we,
  output logic             misalign,
  output logic             bus_error,
  output logic [CNT_W-1:0] access_count
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] WB     = 2'd2;

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    state;
  logic [TW-1:0] tcnt;
  logic [29:0]   lat_word_addr;
  logic [1:0]    lat_lane;
  logic [31:0]   lat_wdata;
  logic [3:0]    lat_be;
  logic          lat_we;
  logic          lat_load;
  logic          lat_byte_load;

  logic        illegal;
  logic        start;
  logic        is_word;
  logic        bad_align;
  logic        accept;
  logic        timeout;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [7:0]  rd_byte;

  // Conflicting decoder strobes are dropped as a no-op rather than guessed at.
  assign illegal   = (mem_read & (word_we | byte_we)) | (word_we & byte_we);
  assign start     = op_valid & (state == IDLE) & (mem_read | word_we | byte_we) & ~illegal;
  assign is_word   = (mem_read & ~byte_load) | word_we;
  assign bad_align = start & is_word & (addr[1:0] != 2'b00);
  assign accept    = start & ~bad_align;
  assign timeout   = (state == ACCESS) & ~mem_ack & (tcnt == TCNT_LAST);

  assign be_next    = word_we ? 4'b1111 : (byte_we ? (4'b0001 << addr[1:0]) : 4'b0000);
  assign wdata_next = byte_we ? {4{store_data[7:0]}} : store_data;

  always_comb begin
    rd_byte = mem_rdata[7:0];
    case (lat_lane)
      2'd1:    rd_byte = mem_rdata[15:8];
      2'd2:    rd_byte = mem_rdata[23:16];
      2'd3:    rd_byte = mem_rdata[31:24];
      default: rd_byte = mem_rdata[7:0];
    endcase
  end

  assign misalign  = bad_align;
  assign stall     = accept | (state == ACCESS);
  assign mem_req   = (state == ACCESS);
  assign mem_we    = lat_we;
  assign mem_be    = lat_be;
  assign mem_addr  = {lat_word_addr, 2'b00};
  assign mem_wdata = lat_wdata;

  // Request fields come from latches so the bus stays stable while the core's
  // inputs move on; ack takes priority over a coinciding timeout.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      tcnt          <= '0;
      lat_word_addr <= '0;
      lat_lane      <= '0;
      lat_wdata     <= '0;
      lat_be        <= '0;
      lat_we        <= 1'b0;
      lat_load      <= 1'b0;
      lat_byte_load <= 1'b0;
      load_data     <= '0;
      rf_we         <= 1'b0;
      bus_error     <= 1'b0;
      access_count  <= '0;
    end else begin
      rf_we     <= 1'b0;
      bus_error <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            lat_word_addr <= addr[31:2];
            lat_lane      <= addr[1:0];
            lat_wdata     <= wdata_next;
            lat_be        <= be_next;
            lat_we        <= word_we | byte_we;
            lat_load      <= mem_read;
            lat_byte_load <= byte_load;
            tcnt          <= '0;
            state         <= ACCESS;
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            if (lat_load)
              load_data <= lat_byte_load ? {24'b0, rd_byte} : mem_rdata;
            rf_we        <= lat_load;
            access_count <= access_count + 1'b1;
            state        <= WB;
          end else if (timeout) begin
            bus_error <= 1'b1;
            state     <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        WB:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_dmem_sequencer.sv
// Randomised self-checking bench for mips_dmem_sequencer; expectations come from
// a per-transaction model of the memory-op rules, not from the DUT.
module tb_mips_dmem_sequencer;

  localparam int TIMEOUT = 64;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        op_valid, mem_read, word_we, byte_we, byte_load;
  logic [31:0] addr, store_data;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall;
  logic [31:0] load_data;
  logic        rf_we, misalign, bus_error;
  logic [15:0] access_count;

  int          vectors;
  int          miscompares;
  logic [15:0] exp_count;

  mips_dmem_sequencer #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(16)) dut (
    .clock(clock), .reset_n(reset_n), .op_valid(op_valid), .mem_read(mem_read),
    .word_we(word_we), .byte_we(byte_we), .byte_load(byte_load), .addr(addr),
    .store_data(store_data), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .stall(stall), .load_data(load_data), .rf_we(rf_we),
    .misalign(misalign), .bus_error(bus_error), .access_count(access_count)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, want %h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic driveOp(input int kind);
    mem_read  = (kind == 0 || kind == 1 || kind == 4 || kind == 5);
    word_we   = (kind == 2 || kind == 5 || kind == 6);
    byte_we   = (kind == 3 || kind == 6);
    byte_load = (kind == 1);
  endtask

  // kind: 0 lw, 1 lbu, 2 sw, 3 sb, 4 addm, 5/6 illegal decodes
  task automatic applyStimulus(input int kind, input logic [31:0] a, input logic [31:0] d,
                               input int ack_delay, input logic [31:0] rd, input bit hold_valid);
    bit          is_load, is_word, legal, aligned, accepted, exp_we, done, timed_out;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata, exp_load;
    is_load   = (kind == 0 || kind == 1 || kind == 4);
    is_word   = (kind == 0 || kind == 2 || kind == 4);
    legal     = (kind < 5);
    aligned   = !(is_word && (a % 4 != 0));
    accepted  = legal && aligned;
    exp_we    = (kind == 2 || kind == 3);
    exp_be    = (kind == 2) ? 4'hF : (kind == 3) ? 4'(1 << (a % 4)) : 4'h0;
    exp_wdata = (kind == 3) ? (d & 32'hFF) * 32'h01010101 : d;
    exp_load  = (kind == 1) ? ((rd >> (8 * (a % 4))) & 32'hFF) : rd;

    @(negedge clock);
    op_valid = 1'b1; driveOp(kind); addr = a; store_data = d; mem_ack = 1'b0;
    #1;
    checkOutput("stall_start", 32'(stall), 32'(accepted));
    checkOutput("misalign", 32'(misalign), 32'(legal && !aligned));
    checkOutput("req_idle", 32'(mem_req), 32'd0);
    if (!accepted) begin
      @(negedge clock);
      op_valid = 1'b0; driveOp(7);
      #1;
      checkOutput("req_none", 32'(mem_req), 32'd0);
      checkOutput("count_kept", 32'(access_count), 32'(exp_count));
      return;
    end

    done = 0; timed_out = 0;
    for (int n = 0; !done; n++) begin
      @(negedge clock);
      mem_ack    = (n == ack_delay);
      mem_rdata  = mem_ack ? rd : $urandom;
      addr       = $urandom;
      store_data = $urandom;
      op_valid   = hold_valid;
      #1;
      checkOutput("req_access", 32'(mem_req), 32'd1);
      checkOutput("stall_access", 32'(stall), 32'd1);
      checkOutput("mem_addr", mem_addr, a & ~32'h3);
      checkOutput("mem_be", 32'(mem_be), 32'(exp_be));
      checkOutput("mem_we", 32'(mem_we), 32'(exp_we));
      if (exp_we) checkOutput("mem_wdata", mem_wdata, exp_wdata);
      checkOutput("bus_err_early", 32'(bus_error), 32'd0);
      if (mem_ack) done = 1;
      else if (n == TIMEOUT - 1) begin done = 1; timed_out = 1; end
    end

    @(negedge clock);
    mem_ack = 1'b0;
    if (timed_out) begin
      op_valid = 1'b0;
      #1;
      checkOutput("bus_error", 32'(bus_error), 32'd1);
      checkOutput("req_timeout", 32'(mem_req), 32'd0);
      checkOutput("stall_timeout", 32'(stall), 32'd0);
      checkOutput("rf_we_timeout", 32'(rf_we), 32'd0);
      checkOutput("count_timeout", 32'(access_count), 32'(exp_count));
    end else begin
      #1;
      exp_count++;
      checkOutput("stall_wb", 32'(stall), 32'd0);
      checkOutput("req_wb", 32'(mem_req), 32'd0);
      checkOutput("bus_err_wb", 32'(bus_error), 32'd0);
      checkOutput("rf_we", 32'(rf_we), 32'(is_load));
      if (is_load) checkOutput("load_data", load_data, exp_load);
      checkOutput("access_count", 32'(access_count), 32'(exp_count));
    end

    @(negedge clock);
    op_valid = 1'b0; driveOp(7);
    #1;
    checkOutput("req_after", 32'(mem_req), 32'd0);
    checkOutput("rf_we_after", 32'(rf_we), 32'd0);
    checkOutput("bus_err_after", 32'(bus_error), 32'd0);
  endtask

  initial begin
    int          kind, dly;
    logic [31:0] a;
    vectors = 0; miscompares = 0; exp_count = '0;
    reset_n = 1'b0; op_valid = 1'b0; driveOp(7);
    addr = '0; store_data = '0; mem_ack = 1'b0; mem_rdata = '0;
    #12;
    checkOutput("rst_req", 32'(mem_req), 32'd0);
    checkOutput("rst_stall", 32'(stall), 32'd0);
    checkOutput("rst_rf_we", 32'(rf_we), 32'd0);
    checkOutput("rst_count", 32'(access_count), 32'd0);
    checkOutput("rst_load_data", load_data, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    applyStimulus(0, 32'h100, 32'h0, 1, 32'hDEADBEEF, 0);
    applyStimulus(1, 32'h103, 32'h0, 0, 32'hAABBCCDD, 0);
    applyStimulus(1, 32'h101, 32'h0, 0, 32'hAABBCCDD, 1);
    applyStimulus(3, 32'h202, 32'h12345678, 0, 32'h0, 0);
    applyStimulus(2, 32'h204, 32'h12345678, 0, 32'h0, 1);
    applyStimulus(2, 32'h206, 32'h12345678, 0, 32'h0, 0);
    applyStimulus(0, 32'h180, 32'h0, 200, 32'h1, 0);
    applyStimulus(0, 32'h184, 32'h0, TIMEOUT - 1, 32'h5555AAAA, 0);
    applyStimulus(4, 32'h188, 32'h0, 2, 32'h0BADF00D, 1);
    applyStimulus(5, 32'h190, 32'h0, 0, 32'h0, 0);
    applyStimulus(6, 32'h194, 32'h0, 0, 32'h0, 0);

    // Reset in the middle of an access must drop the request asynchronously.
    @(negedge clock);
    op_valid = 1'b1; driveOp(0); addr = 32'h300;
    @(negedge clock);
    op_valid = 1'b0;
    #1;
    checkOutput("req_pre_reset", 32'(mem_req), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("req_in_reset", 32'(mem_req), 32'd0);
    checkOutput("stall_in_reset", 32'(stall), 32'd0);
    checkOutput("count_in_reset", 32'(access_count), 32'd0);
    exp_count = '0;
    @(negedge clock);
    reset_n = 1'b1;
    applyStimulus(0, 32'h304, 32'h0, 0, 32'hCAFEF00D, 0);

    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 6);
      a    = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      dly  = ($urandom_range(0, 9) == 0) ? TIMEOUT - 1 : $urandom_range(0, 3);
      applyStimulus(kind, a, $urandom, dly, $urandom, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mips_dmem_sequencer.md
Name: mips_dmem_sequencer

Overview:
- Multi-cycle controller between the MIPS decoder/datapath and a single-ported, variable-latency data memory.
- Sequences the decoded memory operations: lw, lbu, sw, sb, and addm (memory-read half).
- Owns the memory request handshake, byte-lane steering and load-data extraction.
- Stalls the core until each access completes, and generates the register-file write strobe for loads.

Parameters:
- TIMEOUT_CYCLES, 64: maximum cycles the block waits in ACCESS for mem_ack before it raises bus_error.
- CNT_W, 16: width of the completed-access counter.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- op_valid  input  1  the current instruction is valid this cycle.
- mem_read  input  1  decoder: load (lw/lbu/addm).
- word_we  input  1  decoder: sw.
- byte_we  input  1  decoder: sb.
- byte_load  input  1  decoder: lbu.
- addr  input  32  effective address from the ALU.
- store_data  input  32  rt value for stores.
- mem_req  output  1  memory request, held until acknowledged.
- mem_we  output  1  request is a write.
- mem_be  output  4  byte enables.
- mem_addr  output  32  word-aligned address ({addr[31:2],2'b00}).
- mem_wdata  output  32  write data.
- mem_ack  input  1  memory completes the request this cycle.
- mem_rdata  input  32  read data, valid when mem_ack=1.
- stall  output  1  hold PC and pipeline state.
- load_data  output  32  extracted load result, valid while rf_we=1.
- rf_we  output  1  one-cycle register-file write strobe for loads.
- misalign  output  1  one-cycle pulse: word access with addr[1:0]!=0.
- bus_error  output  1  one-cycle pulse: timeout.
- access_count  output  CNT_W  completed accesses, wraps.

Behaviour:
- Clock and reset: single clock. Reset is asynchronous and active-low, on reset_n.
- Reset values: state=IDLE, all outputs 0, internal latches 0, timeout counter 0, access_count 0.
- Reset mid-operation drops mem_req immediately (asynchronously). No rf_we is issued for the aborted access.
- start = op_valid & state==IDLE & (mem_read|word_we|byte_we).
- is_word = (mem_read & ~byte_load) | word_we.
- State IDLE:
  - If start & is_word & addr[1:0]!=0: misalign=1 for one cycle, no request, remain IDLE, stall=0.
  - Else if start: latch addr, store_data, op kind; go to ACCESS.
  - stall=1 combinationally in the start cycle.
- State ACCESS:
  - mem_req=1. mem_we, mem_be, mem_addr and mem_wdata are driven from the latches and held stable until ack. stall=1.
  - Timeout counter increments each cycle without ack.
  - On mem_ack: register the load result, increment access_count, go to WB. mem_req drops in WB.
  - If the counter reaches TIMEOUT_CYCLES-1 with no ack: bus_error pulse, mem_req drops, go to IDLE next cycle. stall is 0 in that IDLE cycle, and no rf_we.
  - If ack and timeout coincide, ack wins.
- State WB:
  - stall=0. rf_we=1 only for loads; load_data is valid. Return to IDLE next cycle.
  - The instruction still presented in WB is not re-accepted, because acceptance happens only in IDLE.
- Minimum load/store latency: 3 cycles (start, ACCESS with same-cycle ack, WB).
- Byte enables: sw gives 4'b1111. sb gives 4'b0001<<addr[1:0]. Loads give 4'b0000.
- Write data: sw passes store_data. sb replicates store_data[7:0] into all four lanes.
- Load data:
  - Word load (lw, addm) returns mem_rdata.
  - lbu returns {24'b0, selected byte}, where lane addr[1:0]=0 is bits[7:0] and 3 is bits[31:24].
- Illegal decode: mem_read together with word_we/byte_we, or word_we&byte_we, is treated as a no-op. No request, stall=0.

Test Plan:
- lw addr=0x100, ack after 2 ACCESS cycles, rdata=0xDEADBEEF -> mem_be=0, mem_addr=0x100, stall high 3 cycles, rf_we one cycle with load_data=0xDEADBEEF, access_count=1.
- lbu addr=0x103, rdata=0xAABBCCDD, same-cycle ack -> load_data=0x000000AA; repeat addr=0x101 -> 0x000000CC.
- sb addr=0x202 store_data=0x12345678 -> mem_we=1, mem_be=4'b0100, mem_wdata=0x78787878, no rf_we; sw addr=0x204 -> mem_be=4'b1111, mem_wdata=0x12345678.
- sw addr=0x206 -> misalign pulse, mem_req never asserted, stall=0, access_count unchanged.
- lw with no ack -> bus_error pulse after TIMEOUT_CYCLES (64) ACCESS cycles, mem_req drops, no rf_we; a late ack then coincides with the timeout cycle -> normal completion, no bus_error.
- Assert reset_n=0 mid-ACCESS -> mem_req and stall go low immediately, state IDLE, access_count=0; next lw after release completes normally.
